// File: rtl/fp_align_if.sv
// Operand, control and result bundle between the FP adder alignment controller
// and its environment (operand source, mantissa shift register, adder stage).
interface fp_align_if #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8
);
  localparam int OP_W = 1 + EXP_W + MAN_W;

  logic             start;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic             sr_q0;
  logic [MAN_W-1:0] sr_data;
  logic             sr_F;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_clear;
  logic             busy;
  logic             done;
  logic [MAN_W:0]   big_mant;
  logic [EXP_W-1:0] exp_out;
  logic             sign_big;
  logic             sign_small;
  logic             swapped;
  logic             sticky;

  modport master (
    output start, a, b, sr_q0,
    input  sr_data, sr_F, sr_load, sr_shift, sr_clear, busy, done,
    input  big_mant, exp_out, sign_big, sign_small, swapped, sticky
  );

  modport slave (
    input  start, a, b, sr_q0,
    output sr_data, sr_F, sr_load, sr_shift, sr_clear, busy, done,
    output big_mant, exp_out, sign_big, sign_small, swapped, sticky
  );
endinterface

// File: rtl/fp_align_ctrl.sv
// Exponent compare and mantissa alignment controller: selects the larger operand,
// loads the smaller mantissa into the shift register and issues the alignment shifts.
module fp_align_ctrl #(
  parameter int MAN_W     = 23,
  parameter int EXP_W     = 8,
  parameter int MAX_SHIFT = 24
) (
  input  logic      clk,
  input  logic      clear,
  fp_align_if.slave bus
);
  localparam int OP_W  = 1 + EXP_W + MAN_W;
  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPARE = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t           state_r;
  logic [OP_W-1:0]  a_r;
  logic [OP_W-1:0]  b_r;
  logic [CNT_W-1:0] count_r;
  logic             sticky_r;
  logic [MAN_W:0]   big_mant_r;
  logic [EXP_W-1:0] exp_out_r;
  logic             sign_big_r;
  logic             sign_small_r;
  logic             swapped_r;
  logic [MAN_W-1:0] sr_data_r;
  logic             sr_f_r;

  logic [EXP_W-1:0] exp_a_s, exp_b_s, exp_big_s, exp_small_s, diff_s;
  logic [MAN_W-1:0] frac_a_s, frac_b_s, frac_big_s, frac_small_s;
  logic             b_big_s, sign_big_s, sign_small_s;

  // Operand selection: larger exponent wins, ties go to the larger fraction, full ties to A.
  always_comb begin
    exp_a_s  = a_r[OP_W-2 -: EXP_W];
    exp_b_s  = b_r[OP_W-2 -: EXP_W];
    frac_a_s = a_r[MAN_W-1:0];
    frac_b_s = b_r[MAN_W-1:0];
    b_big_s  = (exp_b_s > exp_a_s) || ((exp_b_s == exp_a_s) && (frac_b_s > frac_a_s));
    if (b_big_s) begin
      exp_big_s    = exp_b_s;
      exp_small_s  = exp_a_s;
      frac_big_s   = frac_b_s;
      frac_small_s = frac_a_s;
      sign_big_s   = b_r[OP_W-1];
      sign_small_s = a_r[OP_W-1];
    end else begin
      exp_big_s    = exp_a_s;
      exp_small_s  = exp_b_s;
      frac_big_s   = frac_a_s;
      frac_small_s = frac_b_s;
      sign_big_s   = a_r[OP_W-1];
      sign_small_s = b_r[OP_W-1];
    end
    diff_s = exp_big_s - exp_small_s;
  end

  // Control FSM and result registers; clear aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r      <= ST_IDLE;
      a_r          <= '0;
      b_r          <= '0;
      count_r      <= '0;
      sticky_r     <= 1'b0;
      big_mant_r   <= '0;
      exp_out_r    <= '0;
      sign_big_r   <= 1'b0;
      sign_small_r <= 1'b0;
      swapped_r    <= 1'b0;
      sr_data_r    <= '0;
      sr_f_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            state_r <= ST_COMPARE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_COMPARE: begin
          swapped_r    <= b_big_s;
          big_mant_r   <= {(exp_big_s != {EXP_W{1'b0}}), frac_big_s};
          exp_out_r    <= exp_big_s;
          sign_big_r   <= sign_big_s;
          sign_small_r <= sign_small_s;
          sr_data_r    <= frac_small_s;
          sr_f_r       <= (exp_small_s != {EXP_W{1'b0}});
          // Beyond MAX_SHIFT the register is already empty; further shifts add nothing.
          if (diff_s > EXP_W'(MAX_SHIFT)) begin
            count_r <= CNT_W'(MAX_SHIFT);
          end else begin
            count_r <= CNT_W'(diff_s);
          end
          sticky_r <= 1'b0;
          state_r  <= ST_LOAD;
        end
        ST_LOAD: begin
          if (count_r == {CNT_W{1'b0}}) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sticky_r <= sticky_r | bus.sr_q0;
          count_r  <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (count_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sr_clear   = clear | (state_r == ST_COMPARE);
  assign bus.sr_load    = (state_r == ST_LOAD);
  assign bus.sr_shift   = (state_r == ST_SHIFT);
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.done       = (state_r == ST_DONE);
  assign bus.sr_data    = sr_data_r;
  assign bus.sr_F       = sr_f_r;
  assign bus.big_mant   = big_mant_r;
  assign bus.exp_out    = exp_out_r;
  assign bus.sign_big   = sign_big_r;
  assign bus.sign_small = sign_small_r;
  assign bus.swapped    = swapped_r;
  assign bus.sticky     = sticky_r;
endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed bench for fp_align_ctrl with a behavioural 24-bit right-shift register
// attached to the shift-register control outputs.
module tb_fp_align_ctrl;
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  fp_align_if bus_if ();

  fp_align_ctrl dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_if)
  );

  logic [23:0] sr_reg = 24'h0;
  int cyc = 0, shift_cnt = 0, load_cnt = 0, done_cnt = 0;
  int n_cmp = 0, n_err = 0;
  int c0, sh0, ld0, dn0, lat;

  assign bus_if.sr_q0 = sr_reg[0];

  // Downstream mantissa shift register plus event counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.sr_shift) shift_cnt <= shift_cnt + 1;
    if (bus_if.sr_load)  load_cnt  <= load_cnt + 1;
    if (bus_if.done)     done_cnt  <= done_cnt + 1;
    if (bus_if.sr_clear)      sr_reg <= 24'h0;
    else if (bus_if.sr_load)  sr_reg <= {bus_if.sr_F, bus_if.sr_data};
    else if (bus_if.sr_shift) sr_reg <= {1'b0, sr_reg[23:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic launch(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus_if.a = av;
    bus_if.b = bv;
    bus_if.start = 1'b1;
    c0 = cyc; sh0 = shift_cnt; ld0 = load_cnt; dn0 = done_cnt;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus_if.done === 1'b1) begin
        l = cyc - c0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.a = 32'h0;
    bus_if.b = 32'h0;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sr_clear", {31'h0, bus_if.sr_clear}, 32'h1);
    check("rst_busy", {31'h0, bus_if.busy}, 32'h0);
    check("rst_done", {31'h0, bus_if.done}, 32'h0);
    check("rst_sticky", {31'h0, bus_if.sticky}, 32'h0);
    check("rst_big_mant", {8'h0, bus_if.big_mant}, 32'h0);
    check("rst_exp_out", {24'h0, bus_if.exp_out}, 32'h0);
    clear = 1'b0;

    // Scenario 1: diff 1.
    launch(32'h40400000, 32'h3F800000);
    wait_done(lat);
    check("s1_latency", lat, 32'd4);
    check("s1_swapped", {31'h0, bus_if.swapped}, 32'h0);
    check("s1_sr_data", {9'h0, bus_if.sr_data}, 32'h0);
    check("s1_sr_F", {31'h0, bus_if.sr_F}, 32'h1);
    check("s1_exp_out", {24'h0, bus_if.exp_out}, 32'h80);
    check("s1_big_mant", {8'h0, bus_if.big_mant}, 32'hC00000);
    check("s1_sticky", {31'h0, bus_if.sticky}, 32'h0);
    check("s1_shifts", shift_cnt - sh0, 32'd1);
    check("s1_loads", load_cnt - ld0, 32'd1);
    check("s1_sr_reg", {8'h0, sr_reg}, 32'h400000);
    @(negedge clk);
    check("s1_done_width", {31'h0, bus_if.done}, 32'h0);
    check("s1_idle", {31'h0, bus_if.busy}, 32'h0);
    check("s1_hold_exp", {24'h0, bus_if.exp_out}, 32'h80);

    // Scenario 2: equal exponents, B has the larger fraction.
    launch(32'h3F800000, 32'h3FC00000);
    wait_done(lat);
    check("s2_latency", lat, 32'd3);
    check("s2_swapped", {31'h0, bus_if.swapped}, 32'h1);
    check("s2_big_mant", {8'h0, bus_if.big_mant}, 32'hC00000);
    check("s2_exp_out", {24'h0, bus_if.exp_out}, 32'h7F);
    check("s2_shifts", shift_cnt - sh0, 32'd0);
    check("s2_sr_reg", {8'h0, sr_reg}, 32'h800000);

    // Scenario 3: diff 23, low bit set in the smaller fraction.
    launch(32'h4B000000, 32'hBF800001);
    wait_done(lat);
    check("s3_latency", lat, 32'd26);
    check("s3_shifts", shift_cnt - sh0, 32'd23);
    check("s3_sr_reg", {8'h0, sr_reg}, 32'h000001);
    check("s3_sticky", {31'h0, bus_if.sticky}, 32'h1);
    check("s3_sign_small", {31'h0, bus_if.sign_small}, 32'h1);
    check("s3_sign_big", {31'h0, bus_if.sign_big}, 32'h0);
    check("s3_exp_out", {24'h0, bus_if.exp_out}, 32'h96);
    check("s3_big_mant", {8'h0, bus_if.big_mant}, 32'h800000);

    // Scenario 4: diff 127 capped at 24 shifts.
    launch(32'h7F000000, 32'h3F800000);
    wait_done(lat);
    check("s4_latency", lat, 32'd27);
    check("s4_shifts", shift_cnt - sh0, 32'd24);
    check("s4_sr_reg", {8'h0, sr_reg}, 32'h0);
    check("s4_sticky", {31'h0, bus_if.sticky}, 32'h1);
    check("s4_exp_out", {24'h0, bus_if.exp_out}, 32'hFE);

    // Scenario 5: clear during the 10th SHIFT cycle of scenario 3.
    launch(32'h4B000000, 32'hBF800001);
    while (cyc - c0 < 12) @(negedge clk);
    check("s5_in_shift", {31'h0, bus_if.sr_shift}, 32'h1);
    check("s5_prior_shifts", shift_cnt - sh0, 32'd9);
    clear = 1'b1;
    #1;
    check("s5_sr_clear", {31'h0, bus_if.sr_clear}, 32'h1);
    @(negedge clk);
    clear = 1'b0;
    check("s5_busy", {31'h0, bus_if.busy}, 32'h0);
    check("s5_sr_shift", {31'h0, bus_if.sr_shift}, 32'h0);
    check("s5_sticky", {31'h0, bus_if.sticky}, 32'h0);
    check("s5_sr_data", {9'h0, bus_if.sr_data}, 32'h0);
    check("s5_sr_reg", {8'h0, sr_reg}, 32'h0);
    repeat (30) @(negedge clk);
    check("s5_no_done", done_cnt - dn0, 32'd0);
    launch(32'h40400000, 32'h3F800000);
    wait_done(lat);
    check("s5_restart_latency", lat, 32'd4);
    check("s5_restart_big_mant", {8'h0, bus_if.big_mant}, 32'hC00000);
    check("s5_restart_shifts", shift_cnt - sh0, 32'd1);

    // Scenario 6: start pulses while busy and in DONE are ignored.
    launch(32'h4B000000, 32'hBF800001);
    while (cyc - c0 < 8) @(negedge clk);
    bus_if.a = 32'h3F800000;
    bus_if.b = 32'h3FC00000;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done(lat);
    check("s6_latency", lat, 32'd26);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("s6_no_restart", {31'h0, bus_if.busy}, 32'h0);
    @(negedge clk);
    check("s6_still_idle", {31'h0, bus_if.busy}, 32'h0);
    check("s6_shifts", shift_cnt - sh0, 32'd23);
    check("s6_exp_out", {24'h0, bus_if.exp_out}, 32'h96);
    check("s6_swapped", {31'h0, bus_if.swapped}, 32'h0);
    check("s6_sign_small", {31'h0, bus_if.sign_small}, 32'h1);
    check("s6_sticky", {31'h0, bus_if.sticky}, 32'h1);
    check("s6_done_count", done_cnt - dn0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
